// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer.
//   OP_*    : request opcodes (also the alu_4bit opcodes for add/and/or)
//   state_t : sequencer FSM encoding
package alu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/alu_4bit.sv
// Existing 4-bit combinational ALU slice.
//   a, b    : 4-bit operands
//   opcode  : 00 add, 01 sub, 10 and, 11 or
//   cin     : add carry-in / sub borrow-in
//   result  : 4-bit result
//   cout    : add carry-out / sub 1 = no borrow / logic ops 0
module alu_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] opcode,
  input  logic       cin,
  output logic [3:0] result,
  output logic       cout
);
  logic [4:0] sum;
  logic [4:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    diff   = {1'b0, a} - {1'b0, b} - {4'b0, cin};
    result = 4'h0;
    cout   = 1'b0;
    case (opcode)
      2'b00: begin result = sum[3:0];  cout = sum[4];   end
      2'b01: begin result = diff[3:0]; cout = ~diff[4]; end
      2'b10: result = a & b;
      default: result = a | b;
    endcase
  end
endmodule

// File: rtl/alu_nibble_seq.sv
// Wide add/sub/and/or built by stepping one alu_4bit through the operands,
// LS nibble first, carry chained through a register.
//   clk, rst_n                    : clock, async active-low reset
//   in_valid/in_ready             : request handshake
//   in_a, in_b, in_op, in_cin     : W-bit operands, opcode, carry/borrow in
//   out_valid/out_ready           : result handshake
//   out_result, out_cout, out_zero: result, carry (sub: 1 = no borrow), zero flag
module alu_nibble_seq
  import alu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic [1:0]           in_op,
  input  logic                 in_cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_result,
  output logic                 out_cout,
  output logic                 out_zero
);
  localparam int W  = 4*NIBBLES;
  localparam int CW = $clog2(NIBBLES);

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   a_sh, b_sh, res_sh;
  logic [1:0]     op_q;
  logic           carry;

  logic [3:0]     b_nib, alu_res;
  logic [1:0]     alu_op;
  logic           alu_cout;
  logic           accept, last_nib, logic_op;

  assign logic_op = op_q[1];
  assign accept   = in_valid && (state == IDLE);
  assign last_nib = (cnt == CW'(NIBBLES-1));

  // Subtract is A + ~B + carry on the adder; the ALU's own sub is never used.
  assign b_nib  = (op_q == OP_SUB) ? ~b_sh[3:0] : b_sh[3:0];
  assign alu_op = logic_op ? op_q : OP_ADD;

  alu_4bit u_alu (
    .a      (a_sh[3:0]),
    .b      (b_nib),
    .opcode (alu_op),
    .cin    (carry),
    .result (alu_res),
    .cout   (alu_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last_nib)  state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      op_q   <= OP_ADD;
      carry  <= 1'b0;
    end else if (accept) begin
      a_sh  <= in_a;
      b_sh  <= in_b;
      op_q  <= in_op;
      cnt   <= '0;
      case (in_op)
        OP_ADD:  carry <= in_cin;
        OP_SUB:  carry <= ~in_cin;  // borrow-in becomes the inverted carry-in
        default: carry <= 1'b0;
      endcase
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 4;
      b_sh   <= b_sh >> 4;
      res_sh <= {alu_res, res_sh[W-1:4]};
      carry  <= logic_op ? 1'b0 : alu_cout;
      cnt    <= cnt + CW'(1);
    end
  end

  // Outputs are qualified by DONE so the partial result never shows while running.
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign out_result = out_valid ? res_sh : '0;
  assign out_cout   = out_valid & carry;
  assign out_zero   = out_valid & (res_sh == '0);
endmodule

// File: tb/tb_alu_nibble_seq.sv
module tb_alu_nibble_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] in_a, in_b;
  logic [1:0]  in_op;
  logic        in_cin;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic        out_cout, out_zero;

  alu_nibble_seq #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_cout(out_cout), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        cout;
    logic        zero;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Monitor: compares every result the consumer actually takes.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = out_valid;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result",  {16'b0, out_result}, {16'b0, e.res});
        chk("cout",    {31'b0, out_cout},   {31'b0, e.cout});
        chk("zero",    {31'b0, out_zero},   {31'b0, e.zero});
        chk("latency", rise_cyc - e.acc,    32'd4);
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic [15:0] r, input logic co, input logic z);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      e.res = r; e.cout = co; e.zero = z; e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (sb.size() != 0) chk("drain_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_out_valid"},  {31'b0, out_valid},  32'd0);
    chk({tag, "_in_ready"},   {31'b0, in_ready},   32'd1);
    chk({tag, "_out_result"}, {16'b0, out_result}, 32'd0);
    chk({tag, "_out_cout"},   {31'b0, out_cout},   32'd0);
    chk({tag, "_out_zero"},   {31'b0, out_zero},   32'd0);
  endtask

  initial begin
    logic [15:0] held_res;
    logic        held_co, held_z;
    int          n;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 2'b00;
    in_cin = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;

    // op, a, b, cin -> result, cout, zero
    send(2'b00, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    send(2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
    send(2'b00, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b0);
    send(2'b01, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b1, 1'b0);
    send(2'b01, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    send(2'b01, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b1);
    send(2'b01, 16'h0010, 16'h0001, 1'b1, 16'h000E, 1'b1, 1'b0);
    send(2'b10, 16'hF0F0, 16'hFF00, 1'b0, 16'hF000, 1'b0, 1'b0);
    send(2'b11, 16'hF0F0, 16'hFF00, 1'b0, 16'hFFF0, 1'b0, 1'b0);
    send(2'b10, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 1'b0, 1'b0);
    send(2'b11, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1);
    drain();

    // Backpressure: hold out_ready low in DONE with a competing request.
    out_ready = 1'b0;
    send(2'b00, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_valid_seen", {31'b0, out_valid}, 32'd1);
    held_res = out_result; held_co = out_cout; held_z = out_zero;
    in_op = 2'b00; in_a = 16'h1111; in_b = 16'h1111; in_cin = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid",    {31'b0, out_valid},  32'd1);
      chk("bp_result",   {16'b0, out_result}, {16'b0, held_res});
      chk("bp_result_v", {16'b0, out_result}, 32'h0007);
      chk("bp_cout",     {31'b0, out_cout},   {31'b0, held_co});
      chk("bp_zero",     {31'b0, out_zero},   {31'b0, held_z});
      chk("bp_in_ready", {31'b0, in_ready},   32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_after", {31'b0, in_ready},  32'd1);
    chk("bp_valid_after", {31'b0, out_valid}, 32'd0);
    chk("bp_sb_empty",    sb.size(),          32'd0);
    send(2'b11, 16'h00FF, 16'h0F00, 1'b0, 16'h0FFF, 1'b0, 1'b0);
    drain();

    // Reset after two nibbles have retired.
    send(2'b00, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    check_reset_vals("midrst_hold");
    rst_n = 1'b1;
    send(2'b01, 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b1, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
